imm_extend_pipe: RTL
====================

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter IN_W, default 16: raw immediate field width.
REQ-002 Parameter OUT_W, default 32: extended immediate width.
REQ-003 Parameter SHIFT, default 2: left-shift amount for branch-offset mode.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  producer presents instr and mode.
REQ-007 in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready at a clk edge.
REQ-008 instr  input  IN_W  raw immediate field.
REQ-009 mode  input  2  extension mode: 0 SEXT, 1 ZEXT, 2 SEXT_SHL, 3 UPPER.
REQ-010 out_valid  output  1  ext_imm and out_mode are valid.
REQ-011 out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready at a clk edge.
REQ-012 ext_imm  output  OUT_W  extended immediate.
REQ-013 out_mode  output  2  mode that produced ext_imm.
REQ-014 ext_count  output  16  accepted-output count; present only with IMM_EXT_STATS_EN.

Function
REQ-015 SEXT: ext_imm = instr sign-extended from bit IN_W-1 to OUT_W.
REQ-016 ZEXT: ext_imm = instr zero-extended to OUT_W.
REQ-017 SEXT_SHL: ext_imm = (SEXT value) << SHIFT, truncated to OUT_W; vacated low bits are 0.
REQ-018 UPPER: ext_imm[OUT_W-1 -: IN_W] = instr and all lower bits are 0.
REQ-019 Extension is computed combinationally on input; the result is captured in the output register, giving 1-cycle latency from input transfer to out_valid.
REQ-020 Storage: one output register plus one skid register; in_ready = !skid_valid, registered, with no combinational path from out_ready.
REQ-021 Output register empty, or out_ready high: an accepted input loads the output register, or the skid register's contents load first if the skid register is valid.
REQ-022 Output register full, out_ready low, input accepted: the input goes to the skid register and in_ready drops the next cycle.
REQ-023 Skid register full and out_ready high: the skid register moves to the output register, the skid register empties, and in_ready rises the next cycle.
REQ-024 Simultaneous input and output transfers with the skid register empty: the output register reloads with the new value and out_valid stays high.
REQ-025 Ordering is strictly FIFO; no transaction is dropped or duplicated.
REQ-026 ext_imm and out_mode are held stable while out_valid && !out_ready.
REQ-027 Elaboration fails if OUT_W < IN_W + SHIFT or IN_W < 2.

Reset
REQ-028 While rst is high: out_valid = 0, skid_valid = 0, in_ready = 1, ext_imm = 0, out_mode = 0, ext_count = 0.
REQ-029 rst asserted mid-transfer discards the in-flight and skid contents; the first post-reset output is the first input accepted after rst deasserts.

Configuration
REQ-030 Macro IMM_EXT_STATS_EN defined: ext_count increments on each output transfer and saturates at 16'hFFFF (no wrap).
REQ-031 Macro IMM_EXT_STATS_EN undefined: the ext_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-032 Shared package imm_ext_pkg holds the 2-bit mode type with enumerators SEXT, ZEXT, SEXT_SHL, UPPER, and the default width constants.
REQ-033 Pure extension logic lives in combinational sub-module imm_ext_core (instr, mode -> value); imm_extend_pipe instantiates it once, ahead of the skid/output registers.

Verification
REQ-034 Defaults, SEXT: instr 16'h0001 -> ext_imm 32'h00000001; instr 16'h8001 -> 32'hFFFF8001; each arrives 1 cycle after acceptance.
REQ-035 ZEXT 16'h8001 -> 32'h00008001; SEXT_SHL 16'hFFFF -> 32'hFFFFFFFC; UPPER 16'h1234 -> 32'h12340000.
REQ-036 Back-pressure: out_ready low while 3 inputs are offered -> 2 accepted, in_ready low after the 2nd; release out_ready -> both emerge in order, then the 3rd is accepted.
REQ-037 Streaming with out_ready held high and in_valid held high -> one output per cycle, in_ready never drops.
REQ-038 rst asserted with the skid register full -> out_valid = 0 and in_ready = 1 during reset; the next output after reset is the first post-reset input.
REQ-039 With IMM_EXT_STATS_EN defined: 5 output transfers -> ext_count = 5; preload near saturation -> ext_count holds at 16'hFFFF.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for the immediate-extension pipeline.
//   imm_mode_e    : 2-bit extension mode (SEXT, ZEXT, SEXT_SHL, UPPER)
//   IMM_IN_W      : default raw immediate field width
//   IMM_OUT_W     : default extended immediate width
//   IMM_SHIFT     : default left-shift for branch-offset mode
//   IMM_CNT_W     : width of the optional accepted-output counter
// -----------------------------------------------------------------------------
package imm_ext_pkg;

   typedef enum logic [1:0] {
      SEXT     = 2'd0,
      ZEXT     = 2'd1,
      SEXT_SHL = 2'd2,
      UPPER    = 2'd3
   } imm_mode_e;

   localparam int IMM_IN_W  = 16;
   localparam int IMM_OUT_W = 32;
   localparam int IMM_SHIFT = 2;
   localparam int IMM_CNT_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extender.
//   instr : raw immediate field (IN_W bits)
//   mode  : extension mode (imm_mode_e)
//   value : extended immediate (OUT_W bits)
// -----------------------------------------------------------------------------
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W,
   parameter int SHIFT = IMM_SHIFT
) (
   input  logic [IN_W-1:0]  instr,
   input  imm_mode_e        mode,
   output logic [OUT_W-1:0] value
);

   logic [OUT_W-1:0] sext_val;
   logic [OUT_W-1:0] zext_val;

   // Size-casting a signed operand replicates its top bit, which gives the
   // sign extension without a zero-width replication when OUT_W == IN_W.
   assign sext_val = OUT_W'($signed(instr));
   assign zext_val = OUT_W'(instr);

   always_comb begin
      value = '0;
      unique case (mode)
         SEXT:     value = sext_val;
         ZEXT:     value = zext_val;
         SEXT_SHL: value = sext_val << SHIFT;
         UPPER:    value = zext_val << (OUT_W - IN_W);
         default:  value = '0;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Valid/ready wrapped immediate extender with a one-entry skid buffer.
// The extension is done combinationally on the input side and captured in
// the output register, so results appear one cycle after acceptance.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : input handshake (in_ready is a pure flop output)
//   instr, mode       : raw immediate and extension mode
//   out_valid/out_ready : output handshake
//   ext_imm, out_mode : extended immediate and the mode that produced it
//   ext_count         : saturating count of output transfers, present only
//                       when the macro IMM_EXT_STATS_EN is defined
// -----------------------------------------------------------------------------
module imm_extend_pipe
   import imm_ext_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W,
   parameter int SHIFT = IMM_SHIFT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  instr,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] ext_imm,
   output logic [1:0]       out_mode
`ifdef IMM_EXT_STATS_EN
   ,
   output logic [IMM_CNT_W-1:0] ext_count
`endif
);

   if (OUT_W < IN_W + SHIFT || IN_W < 2) begin : g_bad_params
      $error("imm_extend_pipe: requires OUT_W >= IN_W + SHIFT and IN_W >= 2");
   end

   logic [OUT_W-1:0] core_value;

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_imm_q,   out_imm_d;
   logic [1:0]       out_mode_q,  out_mode_d;
   logic             skid_valid_q, skid_valid_d;
   logic [OUT_W-1:0] skid_imm_q,   skid_imm_d;
   logic [1:0]       skid_mode_q,  skid_mode_d;

   logic in_fire;
   logic out_fire;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_core (
      .instr (instr),
      .mode  (imm_mode_e'(mode)),
      .value (core_value)
   );

   assign in_ready  = !skid_valid_q;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid_q && out_ready;
   assign out_valid = out_valid_q;
   assign ext_imm   = out_imm_q;
   assign out_mode  = out_mode_q;

   // The skid entry only fills while in_ready is high, so when it is valid
   // no new input can arrive in the same cycle; draining it always wins.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_imm_d    = out_imm_q;
      out_mode_d   = out_mode_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_mode_d  = skid_mode_q;

      if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_mode_d   = skid_mode_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            out_valid_d = 1'b1;
            out_imm_d   = core_value;
            out_mode_d  = mode;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = core_value;
         skid_mode_d  = mode;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_imm_q    <= '0;
         out_mode_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_mode_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_imm_q    <= out_imm_d;
         out_mode_q   <= out_mode_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_mode_q  <= skid_mode_d;
      end
   end

`ifdef IMM_EXT_STATS_EN
   logic [IMM_CNT_W-1:0] ext_count_q, ext_count_d;

   // Counter sticks at all-ones rather than wrapping.
   always_comb begin
      ext_count_d = ext_count_q;
      if (out_fire && (ext_count_q != {IMM_CNT_W{1'b1}})) begin
         ext_count_d = ext_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_count_q <= '0;
      end else begin
         ext_count_q <= ext_count_d;
      end
   end

   assign ext_count = ext_count_q;
`else
   logic unused_out_fire;
   assign unused_out_fire = out_fire;
`endif

endmodule
